mac_accum_param_1: RTL and testbench
====================================

# mac_accum_param_1

Pipelined signed multiply-accumulate engine that produces the 44-bit convolution sum and the `count_sload` term counter consumed by the downstream ReLU/truncation stage. It accepts one pixel/weight pair per cycle, accumulates exactly `KERNEL_TERMS` products per output window, and publishes each completed sum on `result`. `result` is held stable until the next window completes, so the consumer can sample it when `count_sload==2`. It sits between the line-buffer/weight-ROM fetch logic and the ReLU stage in each convolution lane.

## Interface
- `DATA_WIDTH`, 16, signed width of pixel, weight and optional bias.
- `ACCUM_DATA_WIDTH`, 44, signed accumulator and result width.
- `COUNT_SLOAD_BITWIDTH`, 4, width of the term counter.
- `KERNEL_TERMS`, 9, products per output window. Legal range is 3 to 2^COUNT_SLOAD_BITWIDTH−1.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: pipeline advance; low freezes every register.
- `in_valid` in 1: `data_in`/`weight_in` carry a term this cycle.
- `data_in` in DATA_WIDTH: signed pixel.
- `weight_in` in DATA_WIDTH: signed weight.
- `bias` in DATA_WIDTH: signed bias. Present only with `MAC_BIAS_EN`.
- `result` out ACCUM_DATA_WIDTH: signed completed window sum, held between completions.
- `count_sload` out COUNT_SLOAD_BITWIDTH: number of terms absorbed into the current window.
- `result_valid` out 1: one-cycle pulse when `result` updates.

## Operation
- **Stage 1:** on an edge with `enable && in_valid`, register `data_in`, `weight_in` and a valid bit. With `enable` high and `in_valid` low, the stage-1 valid bit clears, creating a bubble.
- **Stage 2:** register the signed product. The product is 2·DATA_WIDTH bits and carries its own valid bit.
- **Stage 3:** acts only when the stage-2 valid bit is set.
  - `term_idx` (internal) is 0 for the first term of a window. When 0, the accumulator loads the sign-extended product; otherwise it adds the product.
  - When `term_idx==KERNEL_TERMS-1`: `result <= acc + product`, `result_valid <= 1`, `term_idx <= 0`, `count_sload <= 0`.
  - Otherwise: `term_idx` increments and `count_sload <= term_idx+1`.
- `result_valid` is 0 in every cycle in which no window completes.
- Arithmetic is two's complement modulo 2^ACCUM_DATA_WIDTH. There is no saturation; overflow wraps.
- Bubbles (`in_valid` low) never advance `term_idx` or `count_sload`. A window may span any number of bubbles.
- `enable` low holds all stage registers, `term_idx`, `acc`, `result`, `count_sload` and `result_valid` at their current values. Terms presented while `enable` is low are ignored.
- **Reset:** all registers clear to 0 immediately. This includes `result`, `count_sload`, `result_valid` and `term_idx`. A window in progress is discarded, and the next accepted term starts a new window.

## Timing
- A term accepted at edge E reaches the accumulator at edge E+2, assuming `enable` stays high.
- When the last term of a window is accepted at E:
  - `result` and `result_valid` update at E+2.
  - `count_sload` reads 0 after E+2.
- With back-to-back terms:
  - `count_sload` reads 2 after edge E+4, where `result` already holds the finished sum.
  - Steady throughput is one window per KERNEL_TERMS cycles with no dead cycles between windows.
- Any cycle with `enable` low extends every latency above by one cycle.

## Configuration
- `MAC_BIAS_EN`:
  - **Defined:** the `bias` port exists. On a window's first term the accumulator loads product + (sign-extended `bias` << 12), aligning the bias to the Q.12 point used downstream. `bias` is sampled alongside that first term in stage 1.
  - **Undefined:** no `bias` port; the first term loads the product only.

## Test plan
- **Basic window:** 9 back-to-back terms with `data_in`=4096, `weight_in`=2048 → `result`=0x4800000 and a single `result_valid` pulse 2 edges after the 9th term; `count_sload` sequence 1..8, 0.
- **Negative sums:** 9 terms with `data_in`=−4096, `weight_in`=4096 → `result`=−150994944, sign-extended across all 44 bits; then 9 terms of 1×1 → `result`=9, and `result` holds −150994944 until that second completion.
- **Bubbles and enable stalls:** the same 9 terms with `in_valid` low every other cycle, plus 3 cycles of `enable` low in the middle → same `result` 0x4800000; no `count_sload` change during bubbles or stalls; `result_valid` pulses exactly once.
- **Reset mid-window:** assert `reset` after 5 terms, release, then supply 9 terms of 1×1 → outputs 0 during reset, then `result`=9 (not 14).
- **Consumer alignment:** continuous windows of 9 → at every cycle with `count_sload==2`, `result` equals the previous window's expected sum.
- **Bias (with `MAC_BIAS_EN`):** `bias`=0x0100 with 9 terms of 4096×2048 → `result`=0x4900000.

Source files
------------

// File: rtl/mac_accum_param_1.sv
// mac_accum_param_1
//   Three-stage signed multiply-accumulate for one convolution lane.
//   Accumulates KERNEL_TERMS pixel*weight products per output window and
//   publishes each finished sum on `result`, held until the next window
//   completes. The downstream ReLU/truncation stage samples `result` when
//   `count_sload==2`.
//
//   Optional feature macro: MAC_BIAS_EN
//     defined   -> `bias` port exists. The first term of each window loads
//                  product + (sext(bias) << 12), which puts the bias on the
//                  Q.12 grid used downstream.
//     undefined -> no `bias` port. The first term loads the product only.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   enable       pipeline advance; low freezes every register
//   in_valid     data_in/weight_in carry a term this cycle
//   data_in      signed pixel            [DATA_WIDTH]
//   weight_in    signed weight           [DATA_WIDTH]
//   bias         signed bias, MAC_BIAS_EN only [DATA_WIDTH]
//   result       signed window sum, held [ACCUM_DATA_WIDTH]
//   count_sload  terms absorbed into the current window [COUNT_SLOAD_BITWIDTH]
//   result_valid one-cycle pulse when result updates
//
//   Pipeline: S1 registers the operands, S2 registers the product,
//   S3 accumulates. A term accepted at edge E reaches the accumulator at E+2.
//   KERNEL_TERMS must lie in 3 .. 2**COUNT_SLOAD_BITWIDTH-1.

module mac_accum_param_1 #(
  parameter int DATA_WIDTH           = 16,
  parameter int ACCUM_DATA_WIDTH     = 44,
  parameter int COUNT_SLOAD_BITWIDTH = 4,
  parameter int KERNEL_TERMS         = 9
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               in_valid,
  input  logic signed [DATA_WIDTH-1:0]       data_in,
  input  logic signed [DATA_WIDTH-1:0]       weight_in,
`ifdef MAC_BIAS_EN
  input  logic signed [DATA_WIDTH-1:0]       bias,
`endif
  output logic signed [ACCUM_DATA_WIDTH-1:0] result,
  output logic [COUNT_SLOAD_BITWIDTH-1:0]    count_sload,
  output logic                               result_valid
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int AW     = ACCUM_DATA_WIDTH;
  localparam int CW     = COUNT_SLOAD_BITWIDTH;
  localparam int STAGES = 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(KERNEL_TERMS - 1);
`ifdef MAC_BIAS_EN
  localparam int BIAS_SHIFT = 12;
`endif

  // ---------------------------------------------------------------------
  // Valid shift register. Bit 1 is the S1 valid and bit STAGES is the S2
  // valid. Bubbles travel down it as zeros.
  // ---------------------------------------------------------------------
  logic [STAGES:1] vld_pipe_d, vld_pipe_q;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (enable) vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
  end

  // ---------------------------------------------------------------------
  // S1: operand capture. The operands are loaded only for a real term.
  // On a bubble the S1 valid bit clears and the stale operands are ignored.
  // ---------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] a_d, a_q, b_d, b_q;
`ifdef MAC_BIAS_EN
  logic signed [DATA_WIDTH-1:0] bias1_d, bias1_q, bias2_d, bias2_q;
`endif

  always_comb begin
    a_d = a_q;
    b_d = b_q;
`ifdef MAC_BIAS_EN
    bias1_d = bias1_q;
`endif
    if (enable && in_valid) begin
      a_d = data_in;
      b_d = weight_in;
`ifdef MAC_BIAS_EN
      bias1_d = bias;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // S2: registered full-width signed product. The bias travels alongside
  // the product so that it stays paired with its own term.
  // ---------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod_full;
  logic signed [PROD_W-1:0] prod_d, prod_q;

  assign prod_full = a_q * b_q;

  always_comb begin
    prod_d = prod_q;
`ifdef MAC_BIAS_EN
    bias2_d = bias2_q;
`endif
    if (enable) begin
      prod_d = prod_full;
`ifdef MAC_BIAS_EN
      bias2_d = bias1_q;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // S3: accumulate. Sums wrap modulo 2**AW.
  // ---------------------------------------------------------------------
  logic signed [AW-1:0] acc_d, acc_q;
  logic signed [AW-1:0] result_d, result_q;
  logic [CW-1:0]        term_idx_d, term_idx_q;
  logic [CW-1:0]        cnt_d, cnt_q;
  logic                 rv_d, rv_q;

  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] first_base;
  logic signed [AW-1:0] acc_base;
  logic signed [AW-1:0] acc_sum;
  logic                 last_term;

  assign prod_ext = {{(AW-PROD_W){prod_q[PROD_W-1]}}, prod_q};

`ifdef MAC_BIAS_EN
  assign first_base = {{(AW-DATA_WIDTH){bias2_q[DATA_WIDTH-1]}}, bias2_q} <<< BIAS_SHIFT;
`else
  assign first_base = '0;
`endif

  // The first term of a window discards the old accumulator. That term
  // starts from zero, or from the aligned bias when the bias is present.
  assign acc_base  = (term_idx_q == '0) ? first_base : acc_q;
  assign acc_sum   = acc_base + prod_ext;
  assign last_term = (term_idx_q == LAST_IDX);

  always_comb begin
    acc_d      = acc_q;
    result_d   = result_q;
    term_idx_d = term_idx_q;
    cnt_d      = cnt_q;
    rv_d       = rv_q;
    if (enable) begin
      // The result_valid pulse lasts one advancing cycle. With enable low
      // it holds its value like every other register.
      rv_d = 1'b0;
      if (vld_pipe_q[STAGES]) begin
        acc_d = acc_sum;
        if (last_term) begin
          result_d   = acc_sum;
          rv_d       = 1'b1;
          term_idx_d = '0;
          cnt_d      = '0;
        end else begin
          term_idx_d = term_idx_q + 1'b1;
          cnt_d      = term_idx_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // State registers. The reset is asynchronous, so a window in progress is
  // dropped at once.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      term_idx_q <= '0;
      cnt_q      <= '0;
      rv_q       <= 1'b0;
`ifdef MAC_BIAS_EN
      bias1_q    <= '0;
      bias2_q    <= '0;
`endif
    end else begin
      vld_pipe_q <= vld_pipe_d;
      a_q        <= a_d;
      b_q        <= b_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      term_idx_q <= term_idx_d;
      cnt_q      <= cnt_d;
      rv_q       <= rv_d;
`ifdef MAC_BIAS_EN
      bias1_q    <= bias1_d;
      bias2_q    <= bias2_d;
`endif
    end
  end

  assign result       = result_q;
  assign count_sload  = cnt_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_mac_accum_param_1.sv
// Directed bench for mac_accum_param_1. The expected values are computed by hand.
module tb_mac_accum_param_1;
  localparam int DW = 16;
  localparam int AW = 44;
  localparam int CW = 4;
  localparam int KT = 9;

  localparam logic [AW-1:0] BASIC = 44'h4800000;           // 9 * 4096*2048
  localparam logic [AW-1:0] NEG   = AW'(-150994944);       // 9 * -4096*4096
  localparam logic [AW-1:0] NINE  = 44'd9;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 in_valid;
  logic signed [DW-1:0] data_in;
  logic signed [DW-1:0] weight_in;
`ifdef MAC_BIAS_EN
  logic signed [DW-1:0] bias;
`endif
  logic signed [AW-1:0] result;
  logic [CW-1:0]        count_sload;
  logic                 result_valid;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;

  always #5 clock = ~clock;

  mac_accum_param_1 #(
    .DATA_WIDTH(DW), .ACCUM_DATA_WIDTH(AW),
    .COUNT_SLOAD_BITWIDTH(CW), .KERNEL_TERMS(KT)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid),
    .data_in(data_in), .weight_in(weight_in),
`ifdef MAC_BIAS_EN
    .bias(bias),
`endif
    .result(result), .count_sload(count_sload), .result_valid(result_valid)
  );

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge. The outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
    if (result_valid) pulses++;
  endtask

  task automatic drive(input logic en, input logic v, input int d, input int w);
    enable    = en;
    in_valid  = v;
    data_in   = DW'(d);
    weight_in = DW'(w);
  endtask

  // Drives KT back-to-back terms and then 2 idle cycles. The term counter
  // must read 0,0,1..8,0. result must hold prev until the completion edge
  // and show nxt from that edge on.
  task automatic window(input int d, input int w, input logic [AW-1:0] prev,
                        input logic [AW-1:0] nxt, input string tag);
    int p0;
    p0 = pulses;
    for (int k = 0; k < KT + 2; k++) begin
      drive(1'b1, k < KT, d, w);
      tick();
      check({tag, "_cnt"}, AW'(count_sload), AW'((k < 2 || k == KT + 1) ? 0 : k - 1));
      check({tag, "_rv"},  AW'(result_valid), AW'(k == KT + 1));
      if (k == KT) check({tag, "_hold"}, result, prev);
    end
    check({tag, "_res"},    result, nxt);
    check({tag, "_pulses"}, AW'(pulses - p0), AW'(1));
    drive(1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    int p0;
    int hits;
    int m;
    reset = 1'b0;
    drive(1'b1, 1'b0, 0, 0);
`ifdef MAC_BIAS_EN
    bias = '0;
`endif
    // Reset state.
    #12;
    check("rst_res", result, 44'd0);
    check("rst_cnt", AW'(count_sload), 44'd0);
    check("rst_rv",  AW'(result_valid), 44'd0);
    tick();
    reset = 1'b1;
    tick();

    // Basic window, then a negative window, then a 1x1 window.
    window(4096, 2048, 44'd0, BASIC, "basic");
    tick();
    check("basic_rv_drop", AW'(result_valid), 44'd0);
    check("basic_res_held", result, BASIC);
    window(-4096, 4096, BASIC, NEG, "neg");
    check("neg_msb", AW'(result[AW-1]), 44'd1);
    window(1, 1, NEG, NINE, "ones");

    // Bubble on every other cycle, and 3 stalled cycles after term 4.
    // The stalled cycles present a garbage term, which must be ignored.
    p0 = pulses;
    for (int i = 0; i < KT; i++) begin
      drive(1'b1, 1'b1, 4096, 2048);
      tick();
      check("bub_term_cnt", AW'(count_sload), AW'(i));
      check("bub_term_rv",  AW'(result_valid), 44'd0);
      drive(1'b1, 1'b0, 4096, 2048);
      tick();
      check("bub_gap_cnt", AW'(count_sload), AW'(i));
      check("bub_gap_rv",  AW'(result_valid), 44'd0);
      if (i == 4) begin
        for (int s = 0; s < 3; s++) begin
          drive(1'b0, 1'b1, -77, 123);
          tick();
          check("stall_cnt", AW'(count_sload), 44'd4);
          check("stall_rv",  AW'(result_valid), 44'd0);
          check("stall_res", result, NINE);
        end
      end
    end
    drive(1'b1, 1'b0, 0, 0);
    tick();
    check("bub_done_cnt", AW'(count_sload), 44'd0);
    check("bub_done_rv",  AW'(result_valid), 44'd1);
    check("bub_res",      result, BASIC);
    tick();
    check("bub_pulses", AW'(pulses - p0), 44'd1);

    // Reset during a window: 5 terms are dropped, so the next window gives 9.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1, 1);
      tick();
    end
    reset = 1'b0;
    #2;
    check("mid_rst_res", result, 44'd0);
    check("mid_rst_cnt", AW'(count_sload), 44'd0);
    check("mid_rst_rv",  AW'(result_valid), 44'd0);
    tick();
    check("mid_rst_hold_cnt", AW'(count_sload), 44'd0);
    check("mid_rst_hold_res", result, 44'd0);
    reset = 1'b1;
    drive(1'b1, 1'b0, 0, 0);
    window(1, 1, 44'd0, NINE, "post_rst");

    // Continuous windows with sums 54, 81 and 108. Whenever the counter
    // reads 2, result must hold the sum of the previous window.
    p0   = pulses;
    hits = 0;
    for (int k = 0; k < 3 * KT + 2; k++) begin
      drive(1'b1, k < 3 * KT, k / KT + 2, 3);
      tick();
      if (count_sload == 4'd2) begin
        hits++;
        m = (k - 3) / KT;
        check("align_res", result, AW'((m == 0) ? 9 : 27 * (m + 1)));
      end
    end
    check("align_hits",   AW'(hits), 44'd3);
    check("align_pulses", AW'(pulses - p0), 44'd3);
    check("align_last",   result, 44'd108);

`ifdef MAC_BIAS_EN
    // The bias is taken from the first term only: 0x100 << 12 = 0x100000.
    bias = 16'h0100;
    window(4096, 2048, 44'd108, 44'h4900000, "bias");
    bias = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
